// File: rtl/hack_data_mem_if.sv
// hack_data_mem_if: Hack CPU data bus, writeM/addressM/outM out to memory and inM back.
interface hack_data_mem_if #(parameter int DW = 16, parameter int AW = 15);
  logic          writeM;
  logic [AW-1:0] addressM;
  logic [DW-1:0] outM;
  logic [DW-1:0] inM;
  modport master (output writeM, addressM, outM, input inM);
  modport slave (input writeM, addressM, outM, output inM);
endinterface

// File: rtl/hack_data_mem.sv
// hack_data_mem: Hack CPU data-side memory with RAM, keyboard, LED and timer registers.
// The timer at 0x6002 exists only when HACK_MEM_TIMER_EN is defined.
module hack_data_mem #(
  parameter int DW     = 16,
  parameter int AW     = 15,
  parameter int RAM_AW = 14,
  parameter int LED_W  = 8,
  parameter int PRESC  = 25000
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic             en25m,
  input  logic [7:0]       kbd_code,
  output logic [LED_W-1:0] led,
  hack_data_mem_if.slave   bus
);
  localparam logic [AW-1:0] kbd_a = AW'(16'h6000);
  localparam logic [AW-1:0] led_a = AW'(16'h6001);
  localparam logic [AW-1:0] tmr_a = AW'(16'h6002);
  if (PRESC < 1) begin : g_presc_chk
    $error("PRESC must be at least 1");
  end
  logic          wr, is_ram, sel_q;
  logic [DW-1:0] mem [2**RAM_AW];
  logic [DW-1:0] ram_q, per_q, per_d, led_q, tmr_q;
  logic [7:0]    s1_q, s2_q;
  assign wr     = en25m && bus.writeM;
  assign is_ram = (bus.addressM >> RAM_AW) == '0;
  // No reset on the array or its read register so a block RAM is inferred; rst still blocks writes.
  always_ff @(posedge clk50m) begin
    if (wr && is_ram && !rst) mem[bus.addressM[RAM_AW-1:0]] <= bus.outM;
    ram_q <= mem[bus.addressM[RAM_AW-1:0]];
  end
  always_comb begin
    per_d = bus.addressM == kbd_a ? DW'(s2_q) :
            bus.addressM == led_a ? led_q :
            bus.addressM == tmr_a ? tmr_q : '0;
  end
  // sel_q clears on reset so inM reads 0 regardless of the unreset RAM output.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      sel_q <= 1'b0;
      per_q <= '0;
      led_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      sel_q <= is_ram;
      per_q <= per_d;
      s1_q  <= kbd_code;
      s2_q  <= s1_q;
      if (wr && bus.addressM == led_a) led_q <= bus.outM;
    end
  end
  assign bus.inM = sel_q ? ram_q : per_q;
  assign led     = led_q[LED_W-1:0];
`ifdef HACK_MEM_TIMER_EN
  localparam int PW = $clog2(PRESC + 1);
  logic          tick, tmr_wr;
  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] tmr_d;
  always_comb begin
    tmr_wr = wr && bus.addressM == tmr_a;
    tick   = en25m && pre_q == PW'(PRESC - 1);
    pre_d  = (tmr_wr || tick) ? '0 : en25m ? pre_q + 1'b1 : pre_q;
    tmr_d  = tmr_wr ? bus.outM : tick ? tmr_q + 1'b1 : tmr_q;
  end
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      tmr_q <= '0;
    end else begin
      pre_q <= pre_d;
      tmr_q <= tmr_d;
    end
  end
`else
  assign tmr_q = '0;
`endif
endmodule

// File: tb/tb_hack_data_mem.sv
// tb_hack_data_mem: randomized scoreboard bench for hack_data_mem against an address-map model.
module tb_hack_data_mem;
  localparam int PRESC = 4;
  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
    logic [7:0]  l;
  } item_t;
  logic       clk50m = 1'b0;
  logic       rst, en25m, mon_v;
  logic [7:0] kbd_code, led;
  int         checks = 0, errors = 0;
  item_t      sb[$];
  item_t      it;
  logic [15:0] ram_m [int];
  logic [15:0] led_m = 16'h0, tbase = 16'h0;
  int          ticks = 0;
  logic [7:0]  kbd_prev = 8'h0;
  hack_data_mem_if #(.DW(16), .AW(15)) bus ();
  hack_data_mem #(.PRESC(PRESC)) dut (
    .clk50m(clk50m), .rst(rst), .en25m(en25m), .kbd_code(kbd_code), .led(led), .bus(bus.slave)
  );
  always #5 clk50m = ~clk50m;
  function automatic void check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endfunction
  function automatic logic [15:0] tmr_m();
`ifdef HACK_MEM_TIMER_EN
    return tbase + 16'(ticks / PRESC);
`else
    return 16'h0;
`endif
  endfunction
  function automatic logic [15:0] exp_rd(input logic [14:0] a);
    if (a < 15'h4000) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 16'h0;
    if (a == 15'h6000) return {8'h00, kbd_prev};
    if (a == 15'h6001) return led_m;
    if (a == 15'h6002) return tmr_m();
    return 16'h0;
  endfunction
  // Effects of one en25m=1 edge on the architectural state.
  function automatic void model_edge();
    logic tw;
    tw = 1'b0;
    if (bus.writeM) begin
      if (bus.addressM < 15'h4000) ram_m[int'(bus.addressM)] = bus.outM;
      else if (bus.addressM == 15'h6001) led_m = bus.outM;
`ifdef HACK_MEM_TIMER_EN
      else if (bus.addressM == 15'h6002) begin
        tbase = bus.outM;
        ticks = 0;
        tw = 1'b1;
      end
`endif
    end
    if (!tw) ticks++;
  endfunction
  task automatic txn(input logic w, input logic [14:0] a, input logic [15:0] d, input logic [7:0] k,
                     input logic chk);
    kbd_prev = kbd_code;
    @(negedge clk50m);
    kbd_code = k; en25m = 1'b1; mon_v = 1'b0;
    bus.writeM = w; bus.addressM = a; bus.outM = d;
    @(posedge clk50m);
    model_edge();
    if (chk) sb.push_back('{a, exp_rd(a), led_m[7:0]});
    @(negedge clk50m);
    en25m = 1'b0; mon_v = chk;
    @(posedge clk50m);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) txn(1'b0, 15'h7F00, 16'h0, kbd_code, 1'b0);
  endtask
  always @(posedge clk50m) begin
    if (mon_v) begin
      #2;
      if (sb.size() == 0) check("sb_empty", 16'h0, 16'h1);
      else begin
        it = sb.pop_front();
        check($sformatf("inM@%h", it.a), bus.inM, it.d);
        check($sformatf("led@%h", it.a), {8'h0, led}, {8'h0, it.l});
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [14:0] a;
    logic [14:0] hi [4];
    hi = '{15'h2000, 15'h2001, 15'h2002, 15'h3FFF};
    rst = 1'b1; en25m = 1'b0; mon_v = 1'b0; kbd_code = 8'h0;
    bus.writeM = 1'b0; bus.addressM = 15'h0; bus.outM = 16'h0;
    repeat (3) @(posedge clk50m);
    #1;
    check("reset_inM", bus.inM, 16'h0);
    check("reset_led", {8'h0, led}, 16'h0);
    @(negedge clk50m) rst = 1'b0;
    for (int i = 0; i < 32; i++) txn(1'b1, 15'(i), 16'($urandom), 8'h0, 1'b0);
    for (int i = 0; i < 4; i++) txn(1'b1, hi[i], 16'($urandom), 8'h0, 1'b0);
    txn(1'b0, 15'h0006, 16'h0, 8'h0, 1'b1);
    txn(1'b1, 15'h0005, 16'h1234, 8'h0, 1'b1);
    txn(1'b0, 15'h0005, 16'h0, 8'h0, 1'b1);
    txn(1'b0, 15'h0006, 16'h0, 8'h0, 1'b1);
    txn(1'b1, 15'h6001, 16'h00A5, 8'h0, 1'b1);
    txn(1'b0, 15'h6001, 16'h0, 8'h0, 1'b1);
    txn(1'b0, 15'h6000, 16'h0, 8'h41, 1'b0);
    @(negedge clk50m);
    en25m = 1'b1; mon_v = 1'b0;
    @(posedge clk50m);
    model_edge();
    #2 check("kbd_3edges", bus.inM, 16'h0041);
    @(negedge clk50m) en25m = 1'b0;
    @(posedge clk50m);
    txn(1'b0, 15'h6000, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h6000, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h7FFF, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h4000, 16'h0, 8'h00, 1'b1);
    txn(1'b1, 15'h6000, 16'hFFFF, 8'h00, 1'b1);
    txn(1'b1, 15'h7FFF, 16'hFFFF, 8'h00, 1'b1);
    txn(1'b1, 15'h4000, 16'hFFFF, 8'h00, 1'b1);
    txn(1'b0, 15'h3FFF, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h2000, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h0000, 16'h0, 8'h00, 1'b1);
    txn(1'b1, 15'h6002, 16'h0000, 8'h00, 1'b0);
    idle(7);
    txn(1'b0, 15'h6002, 16'h0, 8'h00, 1'b1);
    txn(1'b1, 15'h6002, 16'hFFFF, 8'h00, 1'b1);
    idle(1);
    txn(1'b0, 15'h6002, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h6002, 16'h0, 8'h00, 1'b1);
    txn(1'b1, 15'h0010, 16'h0001, 8'h00, 1'b1);
    @(negedge clk50m);
    rst = 1'b1; en25m = 1'b1; mon_v = 1'b0;
    bus.writeM = 1'b1; bus.addressM = 15'h0010; bus.outM = 16'hBEEF;
    #1;
    check("async_rst_inM", bus.inM, 16'h0);
    check("async_rst_led", {8'h0, led}, 16'h0);
    @(negedge clk50m) en25m = 1'b0;
    @(negedge clk50m);
    rst = 1'b0; bus.writeM = 1'b0;
    led_m = 16'h0; tbase = 16'h0; ticks = 0;
    idle(1);
    txn(1'b0, 15'h0010, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h6001, 16'h0, 8'h00, 1'b1);
    txn(1'b0, 15'h6002, 16'h0, 8'h00, 1'b1);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 15'($urandom_range(0, 31));
        4:       a = hi[$urandom_range(0, 3)];
        5:       a = 15'h6000;
        6:       a = 15'h6001;
        7:       a = 15'h6002;
        8:       a = 15'($urandom_range(32'h4000, 32'h5FFF));
        default: a = 15'($urandom_range(32'h6003, 32'h7FFF));
      endcase
      txn(1'($urandom), a, 16'($urandom),
          $urandom_range(0, 3) == 0 ? 8'($urandom) : kbd_code, 1'b1);
    end
    @(negedge clk50m) mon_v = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk50m);
    check("drain", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
